// File: rtl/tau_ram_responder.sv
// tau_ram_responder: memory-side responder holding program RAM (P) and
// video RAM (V). After reset it boots P from a word-stream loader, then
// services controller P/V accesses. A read-only scan port into V feeds the display.
module tau_ram_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int P_ADDR_BITS   = 8,
    parameter int V_ADDR_BITS   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_ram_rw,
    input  logic [ADDRESS_WIDTH-1:0] p_ram_address,
    input  logic [DATA_WIDTH-1:0]    p_ram_data,
    output logic [DATA_WIDTH-1:0]    p_ram_q,
    input  logic                     v_ram_rw,
    input  logic [ADDRESS_WIDTH-1:0] v_ram_address,
    input  logic [DATA_WIDTH-1:0]    v_ram_data,
    output logic [DATA_WIDTH-1:0]    v_ram_q,
    input  logic [ADDRESS_WIDTH-1:0] v_scan_address,
    output logic [DATA_WIDTH-1:0]    v_scan_q,
    input  logic                     boot_valid,
    input  logic [DATA_WIDTH-1:0]    boot_data,
    input  logic                     boot_last,
    output logic                     boot_ready,
    output logic                     run_ready,
    output logic                     boot_overflow
);
    localparam int P_DEPTH = 2 ** P_ADDR_BITS;
    localparam int V_DEPTH = 2 ** V_ADDR_BITS;

    typedef enum logic {BOOT, RUN} state_t;

    logic [DATA_WIDTH-1:0] p_mem [0:P_DEPTH-1];
    logic [DATA_WIDTH-1:0] v_mem [0:V_DEPTH-1];

    state_t                 state_q, state_d;
    logic [P_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                   boot_overflow_q, boot_overflow_d;
    logic [DATA_WIDTH-1:0]  p_ram_q_q, p_ram_q_d;
    logic [DATA_WIDTH-1:0]  v_ram_q_q, v_ram_q_d;
    logic [DATA_WIDTH-1:0]  v_scan_q_q, v_scan_q_d;

    logic                   p_we, v_we;
    logic [P_ADDR_BITS-1:0] p_waddr, p_idx;
    logic [V_ADDR_BITS-1:0] v_idx, scan_idx;
    logic [DATA_WIDTH-1:0]  p_wdata;

    // Only the low address bits index the RAMs; upper bits alias.
    assign p_idx    = p_ram_address[P_ADDR_BITS-1:0];
    assign v_idx    = v_ram_address[V_ADDR_BITS-1:0];
    assign scan_idx = v_scan_address[V_ADDR_BITS-1:0];

    // Next-state, RAM write controls and read-data selection.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        boot_overflow_d = boot_overflow_q;
        p_ram_q_d       = '0;
        v_ram_q_d       = '0;
        p_we            = 1'b0;
        v_we            = 1'b0;
        p_waddr         = p_idx;
        p_wdata         = p_ram_data;
        // Scan reads V before any same-edge write lands, so it sees old data.
        v_scan_q_d      = v_mem[scan_idx];
        unique case (state_q)
            BOOT: begin
                // Controller buses are dead while booting; q outputs stay 0.
                if (boot_valid) begin
                    p_we    = 1'b1;
                    p_waddr = ptr_q;
                    p_wdata = boot_data;
                    ptr_d   = ptr_q + 1'b1;
                    if (boot_last) begin
                        state_d = RUN;
                    end else if (ptr_q == {P_ADDR_BITS{1'b1}}) begin
                        // P is full: flag it and release the CPU anyway.
                        boot_overflow_d = 1'b1;
                        state_d         = RUN;
                    end
                end
            end
            RUN: begin
                p_we      = p_ram_rw;
                v_we      = v_ram_rw;
                p_ram_q_d = p_ram_rw ? p_ram_data : p_mem[p_idx];
                v_ram_q_d = v_ram_rw ? v_ram_data : v_mem[v_idx];
            end
            default: state_d = BOOT;
        endcase
    end

    // Control and output registers; synchronous reset leaves RAM untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= BOOT;
            ptr_q           <= '0;
            boot_overflow_q <= 1'b0;
            p_ram_q_q       <= '0;
            v_ram_q_q       <= '0;
            v_scan_q_q      <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            boot_overflow_q <= boot_overflow_d;
            p_ram_q_q       <= p_ram_q_d;
            v_ram_q_q       <= v_ram_q_d;
            v_scan_q_q      <= v_scan_q_d;
        end
    end

    // P RAM write port (loader in BOOT, controller in RUN).
    always_ff @(posedge clk) begin
        if (p_we && !rst) p_mem[p_waddr] <= p_wdata;
    end

    // V RAM write port (controller only).
    always_ff @(posedge clk) begin
        if (v_we && !rst) v_mem[v_idx] <= v_ram_data;
    end

    assign p_ram_q       = p_ram_q_q;
    assign v_ram_q       = v_ram_q_q;
    assign v_scan_q      = v_scan_q_q;
    assign boot_ready    = (state_q == BOOT);
    assign run_ready     = (state_q == RUN);
    assign boot_overflow = boot_overflow_q;
endmodule

// File: tb/tb_tau_ram_responder.sv
// Directed self-checking bench for tau_ram_responder.
module tb_tau_ram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        p_ram_rw, v_ram_rw, boot_valid, boot_last;
    logic [15:0] p_ram_address, p_ram_data, v_ram_address, v_ram_data;
    logic [15:0] v_scan_address, boot_data;
    logic [15:0] p_ram_q, v_ram_q, v_scan_q;
    logic        boot_ready, run_ready, boot_overflow;

    int n_chk  = 0;
    int n_fail = 0;

    tau_ram_responder dut (
        .clk(clk), .rst(rst),
        .p_ram_rw(p_ram_rw), .p_ram_address(p_ram_address), .p_ram_data(p_ram_data), .p_ram_q(p_ram_q),
        .v_ram_rw(v_ram_rw), .v_ram_address(v_ram_address), .v_ram_data(v_ram_data), .v_ram_q(v_ram_q),
        .v_scan_address(v_scan_address), .v_scan_q(v_scan_q),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
        .boot_ready(boot_ready), .run_ready(run_ready), .boot_overflow(boot_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; p_ram_rw = 1'b0; v_ram_rw = 1'b0; boot_valid = 1'b0; boot_last = 1'b0;
        p_ram_address = '0; p_ram_data = '0; v_ram_address = '0; v_ram_data = '0;
        v_scan_address = '0; boot_data = '0;

        // ---- Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_p_q", p_ram_q, 16'h0);
        chk("rst_v_q", v_ram_q, 16'h0);
        chk("rst_scan_q", v_scan_q, 16'h0);
        chk("rst_run_ready", {15'd0, run_ready}, 16'd0);
        chk("rst_overflow", {15'd0, boot_overflow}, 16'd0);
        chk("rst_boot_ready", {15'd0, boot_ready}, 16'd1);

        // ---- Boot three words, last on the third
        boot_valid = 1'b1; boot_data = 16'h1111; step();
        boot_data = 16'h2222; step();
        chk("boot_ready_mid", {15'd0, boot_ready}, 16'd1);
        boot_data = 16'h3333; boot_last = 1'b1; step();
        boot_valid = 1'b0; boot_last = 1'b0;
        chk("boot3_boot_ready", {15'd0, boot_ready}, 16'd0);
        chk("boot3_run_ready", {15'd0, run_ready}, 16'd1);

        // ---- P reads with aliased upper address bits
        p_ram_address = 16'h0101; step();
        chk("p_read_alias1", p_ram_q, 16'h2222);
        p_ram_address = 16'h0000; step();
        chk("p_read_0", p_ram_q, 16'h1111);
        p_ram_address = 16'hFF02; step();
        chk("p_read_alias2", p_ram_q, 16'h3333);

        // ---- P write-through then read back
        p_ram_rw = 1'b1; p_ram_address = 16'h0007; p_ram_data = 16'hCAFE; step();
        chk("p_write_through", p_ram_q, 16'hCAFE);
        p_ram_rw = 1'b0; p_ram_address = 16'h0001; step();
        chk("p_read_after_wr", p_ram_q, 16'h2222);
        p_ram_address = 16'h0007; step();
        chk("p_readback", p_ram_q, 16'hCAFE);

        // ---- V write with concurrent scan of same address
        v_scan_address = 16'h00A5;
        v_ram_rw = 1'b1; v_ram_address = 16'h00A5; v_ram_data = 16'h1234; step();
        chk("v_write_through1", v_ram_q, 16'h1234);
        v_ram_data = 16'hBEEF; step();
        chk("v_write_through2", v_ram_q, 16'hBEEF);
        chk("scan_old_data", v_scan_q, 16'h1234);
        v_ram_rw = 1'b0; step();
        chk("scan_new_data", v_scan_q, 16'hBEEF);
        chk("v_read", v_ram_q, 16'hBEEF);

        // ---- Overflow boot: 256 words with no boot_last
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst2_scan_q", v_scan_q, 16'h0);
        boot_valid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            boot_data = 16'h5000 + 16'(i); step();
        end
        chk("ovf_before_full", {15'd0, boot_overflow}, 16'd0);
        chk("ovf_ready_before_full", {15'd0, boot_ready}, 16'd1);
        boot_data = 16'h50FF; step();
        chk("ovf_flag", {15'd0, boot_overflow}, 16'd1);
        chk("ovf_run_ready", {15'd0, run_ready}, 16'd1);
        chk("ovf_boot_ready", {15'd0, boot_ready}, 16'd0);
        boot_data = 16'hFFFF; step();  // 257th word, must be ignored
        boot_valid = 1'b0;
        p_ram_address = 16'h0000; step();
        chk("ovf_p0_not_overwritten", p_ram_q, 16'h5000);
        p_ram_address = 16'h00FF; step();
        chk("ovf_p255", p_ram_q, 16'h50FF);
        p_ram_address = 16'h0005; step();
        chk("ovf_p5", p_ram_q, 16'h5005);

        // ---- Mid-boot reset; controller writes during boot are ignored
        rst = 1'b1; step(); rst = 1'b0;
        p_ram_rw = 1'b1; p_ram_address = 16'h0005; p_ram_data = 16'hDEAD;
        boot_valid = 1'b1; boot_data = 16'hAAAA; step();
        chk("boot_p_q_zero", p_ram_q, 16'h0);
        boot_data = 16'hBBBB; step();
        boot_valid = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_boot_ready", {15'd0, boot_ready}, 16'd1);
        chk("midrst_run_ready", {15'd0, run_ready}, 16'd0);
        chk("midrst_overflow", {15'd0, boot_overflow}, 16'd0);
        // boot_last without boot_valid must not end boot
        boot_last = 1'b1; step();
        chk("last_no_valid", {15'd0, boot_ready}, 16'd1);
        boot_valid = 1'b1; boot_data = 16'hCCCC; step();
        boot_valid = 1'b0; boot_last = 1'b0;
        p_ram_rw = 1'b0;
        chk("boot1_run_ready", {15'd0, run_ready}, 16'd1);
        step();
        chk("boot_wr_ignored_p5", p_ram_q, 16'h5005);
        p_ram_address = 16'h0001; step();
        chk("kept_p1", p_ram_q, 16'hBBBB);
        p_ram_address = 16'h0000; step();
        chk("reboot_p0", p_ram_q, 16'hCCCC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
